// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational program ROM and
// registers each instruction for decode, resolving JMP locally and BLE via redirect.
module instruction_fetch_unit #(
   parameter int                    ADDR_WIDTH   = 16,
   parameter int                    INSTR_WIDTH  = 28,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = {ADDR_WIDTH{1'b0}},
   parameter logic [3:0]            JMP_OPCODE   = 4'hA
) (
   input  logic                   Clock,
   input  logic                   Reset,
   output logic [ADDR_WIDTH-1:0]  oRomAddress,
   input  logic [INSTR_WIDTH-1:0] iRomInstruction,
   input  logic                   iStall,
   input  logic                   iRedirect,
   input  logic [ADDR_WIDTH-1:0]  iRedirectTarget,
   output logic [INSTR_WIDTH-1:0] oInstruction,
   output logic                   oInstructionValid,
   output logic [ADDR_WIDTH-1:0]  oPC
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t                 state_r, state_s;
   logic [ADDR_WIDTH-1:0]  pc_r, pc_s;
   logic [INSTR_WIDTH-1:0] instr_r, instr_s;
   logic                   valid_r, valid_s;
   logic [ADDR_WIDTH-1:0]  opc_r, opc_s;

   function automatic logic is_jmp(input logic [INSTR_WIDTH-1:0] instr);
      return (instr[INSTR_WIDTH-1 -: 4] == JMP_OPCODE);
   endfunction

   // JMP targets are 8-bit absolute addresses, zero-extended to the PC width
   function automatic logic [ADDR_WIDTH-1:0] jmp_target(input logic [INSTR_WIDTH-1:0] instr);
      return {{(ADDR_WIDTH-8){1'b0}}, instr[INSTR_WIDTH-5 -: 8]};
   endfunction

   // Next-state and next-output computation; redirect beats stall beats JMP beats sequential
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      instr_s = instr_r;
      valid_s = valid_r;
      opc_s   = opc_r;
      case (state_r)
         S_IDLE: begin
            state_s = S_FETCH;
            valid_s = 1'b0;
         end
         S_FETCH, S_FLUSH: begin
            if (iRedirect) begin
               pc_s    = iRedirectTarget;
               valid_s = 1'b0;
               state_s = S_FLUSH;
            end else if (iStall) begin
               state_s = state_r;
            end else begin
               instr_s = iRomInstruction;
               opc_s   = pc_r;
               valid_s = 1'b1;
               state_s = S_FETCH;
               pc_s    = is_jmp(iRomInstruction) ? jmp_target(iRomInstruction)
                                                 : pc_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_s = S_IDLE;
            valid_s = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_r <= S_IDLE;
         pc_r    <= RESET_VECTOR;
         instr_r <= {INSTR_WIDTH{1'b0}};
         valid_r <= 1'b0;
         opc_r   <= {ADDR_WIDTH{1'b0}};
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         instr_r <= instr_s;
         valid_r <= valid_s;
         opc_r   <= opc_s;
      end
   end

   assign oRomAddress       = pc_r;
   assign oInstruction      = instr_r;
   assign oInstructionValid = valid_r;
   assign oPC               = opc_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed steps push expected outputs,
// a negedge monitor pops and compares them against two DUT instances.
module tb_instruction_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, stall1, redir1;
   logic [15:0] tgt1, ra1, pc1;
   logic [27:0] rd1, ins1;
   logic        v1;

   logic        rst2, stall2, redir2;
   logic [15:0] tgt2, ra2, pc2;
   logic [27:0] rd2, ins2;
   logic        v2;

   logic [27:0] rom1 [0:255];
   assign rd1 = rom1[ra1[7:0]];
   assign rd2 = {12'h000, ra2};

   instruction_fetch_unit #(.ADDR_WIDTH(16), .INSTR_WIDTH(28), .RESET_VECTOR(16'h0000),
                            .JMP_OPCODE(4'hA)) dut1 (
      .Clock(clk), .Reset(rst1), .oRomAddress(ra1), .iRomInstruction(rd1),
      .iStall(stall1), .iRedirect(redir1), .iRedirectTarget(tgt1),
      .oInstruction(ins1), .oInstructionValid(v1), .oPC(pc1));

   instruction_fetch_unit #(.ADDR_WIDTH(16), .INSTR_WIDTH(28), .RESET_VECTOR(16'hFFFE),
                            .JMP_OPCODE(4'hA)) dut2 (
      .Clock(clk), .Reset(rst2), .oRomAddress(ra2), .iRomInstruction(rd2),
      .iStall(stall2), .iRedirect(redir2), .iRedirectTarget(tgt2),
      .oInstruction(ins2), .oInstructionValid(v2), .oPC(pc2));

   typedef struct {
      int          due;
      bit          which;
      logic        v;
      logic [15:0] pc;
      logic [27:0] ins;
      logic [15:0] ra;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, req);
      end
   endtask

   // Monitor: compare the DUT outputs against the entry due this cycle
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0 && q[0].due < cyc) begin
         checks++;
         errors++;
         $display("FAIL missed_entry cycle %0d: got none expected due %0d", cyc, q[0].due);
         e = q.pop_front();
      end
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         if (!e.which) begin
            chk("dut1_valid", {27'h0, v1}, {27'h0, e.v});
            chk("dut1_opc", {12'h000, pc1}, {12'h000, e.pc});
            chk("dut1_instr", ins1, e.ins);
            chk("dut1_romaddr", {12'h000, ra1}, {12'h000, e.ra});
         end else begin
            chk("dut2_valid", {27'h0, v2}, {27'h0, e.v});
            chk("dut2_opc", {12'h000, pc2}, {12'h000, e.pc});
            chk("dut2_instr", ins2, e.ins);
            chk("dut2_romaddr", {12'h000, ra2}, {12'h000, e.ra});
         end
      end
   end

   // Drive one cycle of inputs and queue the outputs expected after the coming edge
   task automatic step(input bit w, input logic rst, input logic st, input logic rd,
                       input logic [15:0] tg, input logic ev, input logic [15:0] epc,
                       input logic [15:0] era, input bit zi);
      exp_t e;
      if (!w) begin
         rst1 = rst; stall1 = st; redir1 = rd; tgt1 = tg;
      end else begin
         rst2 = rst; stall2 = st; redir2 = rd; tgt2 = tg;
      end
      e.due   = cyc + 1;
      e.which = w;
      e.v     = ev;
      e.pc    = epc;
      e.ra    = era;
      e.ins   = zi ? 28'h0 : (w ? {12'h000, epc} : rom1[epc[7:0]]);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic seq1(input int pc);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'(pc), 16'(pc + 1), 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++)
         rom1[i] = {4'h1 + 4'(i % 4), 8'(i), 16'(i * 257)};
      rom1[3]  = {4'hF, 8'h33, 16'hBEEF};
      rom1[16] = {4'hA, 8'd6, 16'h1234};
      rom1[40] = {4'hA, 8'd40, 16'h0000};
      rst2 = 1'b1; stall2 = 1'b0; redir2 = 1'b0; tgt2 = 16'h0;

      // reset, idle bubble, sequential run with a 3-cycle stall at oPC=4
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1);
      for (int k = 0; k <= 4; k++) seq1(k);
      repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'd4, 16'd5, 1'b0);
      for (int k = 5; k <= 10; k++) seq1(k);
      // redirect to 9 while PC=11: one bubble then 9
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'd9, 1'b0, 16'd10, 16'd9, 1'b0);
      for (int k = 9; k <= 15; k++) seq1(k);
      // JMP at 16 lands on 6
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'd16, 16'd6, 1'b0);
      seq1(6);
      seq1(7);
      // redirect together with stall: redirect wins
      step(1'b0, 1'b0, 1'b1, 1'b1, 16'd14, 1'b0, 16'd7, 16'd14, 1'b0);
      seq1(14);
      seq1(15);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'd16, 16'd6, 1'b0);
      seq1(6);
      // back-to-back redirects, then stall while flushing
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'd20, 1'b0, 16'd6, 16'd20, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'd30, 1'b0, 16'd6, 16'd30, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'd6, 16'd30, 1'b0);
      seq1(30);
      // JMP to its own address refetches every cycle
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'd40, 1'b0, 16'd30, 16'd40, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'd40, 16'd40, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'd40, 16'd40, 1'b0);

      // reset vector near the top of the address space: wrap, then reset during flush
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0000, 16'hFFFE, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0000, 16'hFFFE, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hFFFE, 16'hFFFF, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 16'h0001, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 16'd5, 1'b0, 16'h0000, 16'h0005, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 16'd7, 1'b0, 16'h0000, 16'hFFFE, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0000, 16'hFFFE, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hFFFE, 16'hFFFF, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
